// File: rtl/i2s_tx.sv
// I2S stereo transmitter: a one-entry holding register feeds a 64-period frame started by
// sample_clk_en. Each 32-period slot carries a one-bit delay, then the sample MSB first, then zeros.
module i2s_tx #(
    parameter int BCLK_DIV     = 16,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_clk_en,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    busy,
    output logic                    underrun,
    output logic                    overrun
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PAD_W = 31 - SAMPLE_WIDTH;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_next;
    logic [DIV_W-1:0]        div_cnt;
    logic [5:0]              bit_cnt;
    logic [5:0]              bit_cnt_inc;
    logic [63:0]             shift_q;
    logic                    bclk_q, lrclk_q, sdata_q, busy_q;
    logic                    underrun_q, overrun_q;
    logic                    hold_full;
    logic [SAMPLE_WIDTH-1:0] hold_l, hold_r, last_l, last_r;
    logic [SAMPLE_WIDTH-1:0] src_l, src_r;
    logic [31:0]             word_l, word_r;
    logic                    accept, div_end, bclk_fall, frame_done;
    logic                    start, over_next;

    assign accept      = sample_valid && !hold_full;
    assign div_end     = (state == RUN) && (div_cnt == DIV_LAST);
    assign bclk_fall   = div_end && bclk_q;
    assign frame_done  = bclk_fall && (bit_cnt == 6'd63);
    assign bit_cnt_inc = bit_cnt + 6'd1;

    // An empty holding register at frame start means the previous pair is sent again.
    assign src_l  = hold_full ? hold_l : last_l;
    assign src_r  = hold_full ? hold_r : last_r;
    assign word_l = {{(32-SAMPLE_WIDTH){1'b0}}, src_l} << PAD_W;
    assign word_r = {{(32-SAMPLE_WIDTH){1'b0}}, src_r} << PAD_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A tick landing in the last cycle of a frame chains straight into the next frame.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        over_next  = 1'b0;
        case (state)
            IDLE: begin
                if (sample_clk_en) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (frame_done) begin
                    if (sample_clk_en) begin
                        start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (sample_clk_en) begin
                    over_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full  <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            last_l     <= '0;
            last_r     <= '0;
            shift_q    <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b1;
            sdata_q    <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            underrun_q <= start && !hold_full;
            overrun_q  <= over_next;

            if (start && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold_l    <= sample_l;
                hold_r    <= sample_r;
            end

            // Shift register holds the frame already advanced past the period-0 bit.
            if (start) begin
                last_l  <= src_l;
                last_r  <= src_r;
                shift_q <= {word_l[30:0], word_r, 1'b0};
                div_cnt <= '0;
                bit_cnt <= '0;
                bclk_q  <= 1'b0;
                lrclk_q <= 1'b0;
                sdata_q <= word_l[31];
                busy_q  <= 1'b1;
            end else if (frame_done) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                bclk_q  <= 1'b0;
                lrclk_q <= 1'b1;
                sdata_q <= 1'b0;
                busy_q  <= 1'b0;
            end else if (state == RUN) begin
                if (div_end) begin
                    div_cnt <= '0;
                    bclk_q  <= !bclk_q;
                    if (bclk_q) begin
                        bit_cnt <= bit_cnt_inc;
                        lrclk_q <= bit_cnt_inc[5];
                        sdata_q <= shift_q[63];
                        shift_q <= {shift_q[62:0], 1'b0};
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign sample_ready = !hold_full;
    assign i2s_bclk     = bclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sdata    = sdata_q;
    assign busy         = busy_q;
    assign underrun     = underrun_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: frames queued at the tick are decoded from the serial line,
// plus a BCLK_DIV=2 instance checked cycle-by-cycle for back-to-back frames.
module tb_i2s_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sample_clk_en = 1'b0, sample_valid = 1'b0;
    logic [23:0] sample_l = '0, sample_r = '0;
    logic        sample_ready, i2s_bclk, i2s_lrclk, i2s_sdata, busy, underrun, overrun;

    logic        en2 = 1'b0, valid2 = 1'b0;
    logic [23:0] l2 = '0, r2 = '0;
    logic        ready2, bclk2, lrclk2, sdata2, busy2, under2, over2;

    i2s_tx #(.BCLK_DIV(16), .SAMPLE_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .sample_clk_en(sample_clk_en),
        .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
        .i2s_sdata(i2s_sdata), .busy(busy), .underrun(underrun), .overrun(overrun)
    );

    i2s_tx #(.BCLK_DIV(2), .SAMPLE_WIDTH(24)) dut2 (
        .clk(clk), .rst(rst), .sample_clk_en(en2),
        .sample_l(l2), .sample_r(r2), .sample_valid(valid2),
        .sample_ready(ready2), .i2s_bclk(bclk2), .i2s_lrclk(lrclk2),
        .i2s_sdata(sdata2), .busy(busy2), .underrun(under2), .overrun(over2)
    );

    int          checks = 0, passes = 0;
    logic [47:0] sb[$];
    logic [47:0] exp_pair;
    logic        m_full = 1'b0;
    logic [23:0] m_hl = '0, m_hr = '0, m_ll = '0, m_lr = '0;
    int          m_left = 0;
    logic        prev_bclk = 1'b0;
    int          nbits = 0;
    logic [63:0] rx = '0;
    logic [23:0] pl[3], pr[3];
    int          rel, f, w, p;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    endtask

    function automatic logic slotBit(input logic [23:0] l, input logic [23:0] r, input int per);
        logic [23:0] word;
        int          s;
        word = (per < 32) ? l : r;
        s    = per % 32;
        if (s >= 1 && s <= 24) return word[24 - s];
        return 1'b0;
    endfunction

    // Decodes dut frames on bclk rising edges and pops the scoreboard after 64 bits.
    always @(negedge clk) begin
        if (!busy) begin
            nbits = 0;
        end else if (i2s_bclk && !prev_bclk) begin
            checkOutput("lrclk_slot", i2s_lrclk, (nbits >= 32));
            rx = {rx[62:0], i2s_sdata};
            nbits++;
            if (nbits == 64) begin
                nbits = 0;
                checkOutput("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_pair = sb.pop_front();
                    checkOutput("left", rx[62:39], exp_pair[47:24]);
                    checkOutput("right", rx[30:7], exp_pair[23:0]);
                    checkOutput("pad_bits", {rx[63], rx[38:32], rx[31], rx[6:0]}, 0);
                end
            end
        end
        prev_bclk = i2s_bclk;
    end

    task automatic step();
        @(negedge clk);
        if (m_left > 0) m_left--;
        checkOutput("busy", busy, m_left > 0);
    endtask

    task automatic applyStimulus(input logic tick, input logic valid, input logic [23:0] l, input logic [23:0] r);
        logic acc, exp_under, exp_over;
        acc       = valid && !m_full;
        exp_under = 1'b0;
        exp_over  = 1'b0;
        checkOutput("ready", sample_ready, !m_full);
        if (tick && m_left <= 1) begin
            if (m_full) begin
                sb.push_back({m_hl, m_hr});
                m_ll   = m_hl;
                m_lr   = m_hr;
                m_full = 1'b0;
            end else begin
                sb.push_back({m_ll, m_lr});
                exp_under = 1'b1;
            end
            m_left = 16 * 128 + 1;
        end else if (tick) begin
            exp_over = 1'b1;
        end
        if (acc) begin
            m_hl   = l;
            m_hr   = r;
            m_full = 1'b1;
        end
        sample_clk_en = tick;
        sample_valid  = valid;
        sample_l      = l;
        sample_r      = r;
        step();
        sample_clk_en = 1'b0;
        sample_valid  = 1'b0;
        checkOutput("underrun", underrun, exp_under);
        checkOutput("overrun", overrun, exp_over);
        checkOutput("ready_next", sample_ready, !m_full);
        if (tick && !exp_over) begin
            checkOutput("t1_bclk", i2s_bclk, 0);
            checkOutput("t1_lrclk", i2s_lrclk, 0);
            checkOutput("t1_sdata", i2s_sdata, 0);
        end
    endtask

    task automatic waitIdle();
        while (m_left > 0) step();
        step();
        checkOutput("idle_bclk", i2s_bclk, 0);
        checkOutput("idle_lrclk", i2s_lrclk, 1);
        checkOutput("idle_sdata", i2s_sdata, 0);
    endtask

    // Reset is asserted together with a tick and a valid pair to show it wins.
    task automatic doReset();
        rst           = 1'b1;
        sample_clk_en = 1'b1;
        sample_valid  = 1'b1;
        sample_l      = 24'hABCDEF;
        sample_r      = 24'h13579B;
        m_left        = 0;
        m_full        = 1'b0;
        m_ll          = '0;
        m_lr          = '0;
        sb.delete();
        step();
        rst           = 1'b0;
        sample_clk_en = 1'b0;
        sample_valid  = 1'b0;
        checkOutput("rst_ready", sample_ready, 1);
        checkOutput("rst_bclk", i2s_bclk, 0);
        checkOutput("rst_lrclk", i2s_lrclk, 1);
        checkOutput("rst_sdata", i2s_sdata, 0);
        checkOutput("rst_underrun", underrun, 0);
        checkOutput("rst_overrun", overrun, 0);
        step();
        checkOutput("rst_ready_after", sample_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got %0d checks, required completion", checks);
        $fatal(1);
    end

    initial begin
        doReset();

        applyStimulus(1'b1, 1'b0, 24'h0, 24'h0);
        waitIdle();

        applyStimulus(1'b0, 1'b1, 24'h800001, 24'h7FFFFF);
        applyStimulus(1'b1, 1'b0, 24'h0, 24'h0);
        waitIdle();

        applyStimulus(1'b0, 1'b1, 24'h123456, 24'h654321);
        applyStimulus(1'b1, 1'b0, 24'h0, 24'h0);
        waitIdle();
        applyStimulus(1'b1, 1'b0, 24'h0, 24'h0);
        waitIdle();

        applyStimulus(1'b0, 1'b1, 24'h0F0F0F, 24'hF0F0F0);
        applyStimulus(1'b1, 1'b0, 24'h0, 24'h0);
        repeat (499) step();
        applyStimulus(1'b1, 1'b0, 24'h0, 24'h0);
        waitIdle();

        applyStimulus(1'b0, 1'b1, 24'hAAAAAA, 24'h555555);
        applyStimulus(1'b0, 1'b1, 24'h111111, 24'h222222);
        applyStimulus(1'b1, 1'b0, 24'h0, 24'h0);
        waitIdle();
        applyStimulus(1'b1, 1'b1, 24'hC0FFEE, 24'hBEEF01);
        waitIdle();
        applyStimulus(1'b1, 1'b0, 24'h0, 24'h0);
        waitIdle();

        applyStimulus(1'b0, 1'b1, 24'hDEADBE, 24'h0BADF0);
        applyStimulus(1'b1, 1'b0, 24'h0, 24'h0);
        repeat (999) step();
        doReset();
        applyStimulus(1'b0, 1'b1, 24'h3C3C3C, 24'hC3C3C3);
        applyStimulus(1'b1, 1'b0, 24'h0, 24'h0);
        waitIdle();
        checkOutput("sb_drained", sb.size(), 0);

        // Back-to-back frames on the fast instance, one tick every 256 cycles.
        pl[0] = 24'hA5A5A5; pr[0] = 24'h5A5A5A;
        pl[1] = 24'h800000; pr[1] = 24'h7FFFFF;
        pl[2] = 24'h000001; pr[2] = 24'hFFFFFE;
        @(negedge clk);
        valid2 = 1'b1; l2 = pl[0]; r2 = pr[0];
        @(negedge clk);
        valid2 = 1'b0;
        checkOutput("b2b_ready_full", ready2, 0);
        for (int n = 0; n <= 770; n++) begin
            if (n >= 1) begin
                rel = n - 1;
                if (rel < 768) begin
                    f = rel / 256;
                    w = rel % 256;
                    p = w / 4;
                    checkOutput("b2b_busy", busy2, 1);
                    checkOutput("b2b_bclk", bclk2, (w % 4) >= 2);
                    checkOutput("b2b_lrclk", lrclk2, p >= 32);
                    checkOutput("b2b_sdata", sdata2, slotBit(pl[f], pr[f], p));
                    checkOutput("b2b_overrun", over2, 0);
                    checkOutput("b2b_underrun", under2, 0);
                end else begin
                    checkOutput("b2b_end_busy", busy2, 0);
                    checkOutput("b2b_end_lrclk", lrclk2, 1);
                end
            end
            en2    = (n < 768) && (n % 256 == 0);
            valid2 = (n == 2) || (n == 258);
            if (valid2) begin
                l2 = pl[n / 256 + 1];
                r2 = pr[n / 256 + 1];
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 16: clk cycles per BCLK half-period; legal range 2 and above.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 24: audio sample width in bits; legal range 1 to 31.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sample_clk_en, input, 1 bit: one-cycle frame-start tick from the sample-rate generator.
REQ-006 SHALL have port sample_l, input, SAMPLE_WIDTH bits: left sample, signed two's complement.
REQ-007 SHALL have port sample_r, input, SAMPLE_WIDTH bits: right sample, signed two's complement.
REQ-008 SHALL have port sample_valid, input, 1 bit: the sample_l/sample_r pair is valid.
REQ-009 SHALL have port sample_ready, output, 1 bit: the holding register is empty.
REQ-010 SHALL have port i2s_bclk, output, 1 bit: bit clock.
REQ-011 SHALL have port i2s_lrclk, output, 1 bit: word select; 0 means left, 1 means right.
REQ-012 SHALL have port i2s_sdata, output, 1 bit: serial data.
REQ-013 SHALL have port busy, output, 1 bit: a frame is being shifted out.
REQ-014 SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame starts with no new sample.
REQ-015 SHALL have port overrun, output, 1 bit: one-cycle pulse when a tick arrives during a frame.

Function
REQ-016 SHALL accept a sample pair into the one-entry holding register on a cycle with sample_valid && sample_ready; sample_ready SHALL then be 0 from the next cycle until the pair is consumed.
REQ-017 SHALL use a two-state FSM, IDLE and RUN; IDLE transitions to RUN on sample_clk_en.
REQ-018 SHALL, on an IDLE tick with the holding register full, load the shift registers from it and mark it empty (sample_ready = 1 on the next cycle).
REQ-019 SHALL, on an IDLE tick with the holding register empty, resend the last transmitted pair (zeros after reset) and pulse underrun in the next cycle.
REQ-020 SHALL treat an accept and a tick in the same cycle with the holding register empty as an underrun; the new pair stays held for the following frame.
REQ-021 SHALL, in the cycle after the tick (T+1), set busy = 1, i2s_bclk = 0, i2s_lrclk = 0 and i2s_sdata = 0.
REQ-022 SHALL toggle i2s_bclk every BCLK_DIV clk cycles while in RUN; one BCLK period is 2*BCLK_DIV cycles.
REQ-023 SHALL send a frame of 64 BCLK periods, numbered 0..63: slot 0..31 left, slot 32..63 right.
REQ-024 SHALL change i2s_lrclk and i2s_sdata only in the cycle where i2s_bclk goes 1->0, or at T+1; the receiver samples on the rising edge.
REQ-025 SHALL drive i2s_lrclk = 0 for periods 0..31 and i2s_lrclk = 1 for periods 32..63.
REQ-026 SHALL drive i2s_sdata within each 32-period slot as follows: bit 0 is 0 (I2S one-bit delay); bits 1..SAMPLE_WIDTH carry the sample MSB first; the remaining bits are 0.
REQ-027 SHALL, after period 63 completes (at T+1+128*BCLK_DIV), return to IDLE: busy = 0, i2s_bclk = 0, i2s_lrclk = 1, i2s_sdata = 0.
REQ-028 SHALL pulse overrun for one cycle when a tick arrives in RUN; that tick is ignored and the current frame continues unaltered.
REQ-029 SHALL allow accepts during RUN; they do not disturb the frame in progress.
REQ-030 SHALL size its counters as follows: div_cnt of clog2(BCLK_DIV) bits, wrapping at BCLK_DIV-1; bit_cnt of 6 bits, wrapping at 63.

Reset
REQ-031 SHALL, while rst = 1, force: FSM = IDLE, holding register empty, last pair = 0, shift registers = 0, counters = 0.
REQ-032 SHALL, while rst = 1, force outputs: sample_ready = 1, busy = 0, i2s_bclk = 0, i2s_lrclk = 1, i2s_sdata = 0, underrun = 0, overrun = 0.
REQ-033 SHALL abort any frame in progress when rst is asserted mid-frame, with outputs reaching reset values in the next cycle; no partial frame resumes afterwards.
REQ-034 SHALL have rst take priority over sample_clk_en and sample_valid in the same cycle.

Verification
REQ-035 SHALL cover this scenario (BCLK_DIV = 16, SAMPLE_WIDTH = 24): load L = 0x800001, R = 0x7FFFFF, then tick -> 64 BCLK periods and busy high for 2048 cycles; the decoded slots equal L and R; bit 0 of each slot = 0; bits 25..31 = 0.
REQ-036 SHALL cover this scenario: tick with no sample after reset -> underrun pulse; a frame of all zeros. Then load 0x123456/0x654321, followed by two ticks with no reload -> the second frame repeats 0x123456/0x654321 with underrun = 1.
REQ-037 SHALL cover this scenario: tick at frame cycle 500 -> overrun pulse at cycle 501; frame length remains 2048 cycles; no second frame starts.
REQ-038 SHALL cover this scenario: sample_valid with holding full -> sample_ready = 0, the held value is unchanged; the tick frees it and sample_ready = 1 in the next cycle; an accept and a tick in the same cycle follow REQ-020.
REQ-039 SHALL cover this scenario: rst at frame cycle 1000 -> next cycle i2s_bclk = 0, i2s_lrclk = 1, busy = 0, sample_ready = 1; a new tick after release starts a clean frame.
REQ-040 SHALL cover this scenario: BCLK_DIV = 2 with a tick every 256 cycles -> back-to-back frames, no overrun, i2s_lrclk contiguous between frames.
